// File: rtl/btn_event_decoder_pkg.sv
// Shared definitions for btn_event_decoder: FSM state encodings and cycle constants
// for the 50 MHz board and for reduced-length simulation.
package btn_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_LONG  = 2'b10
    } btn_state_e;

    localparam int unsigned BOARD_CW         = 26;
    localparam int unsigned BOARD_LONG_CYC   = 50_000_000;
    localparam int unsigned BOARD_REPEAT_CYC = 10_000_000;
    localparam int unsigned BOARD_PCW        = 8;

    localparam int unsigned SIM_CW           = 8;
    localparam int unsigned SIM_LONG_CYC     = 8;
    localparam int unsigned SIM_REPEAT_CYC   = 4;

endpackage

// File: rtl/btn_event_decoder_if.sv
// Event/level bundle between the button decoder (slave) and its consumer (master).
interface btn_event_decoder_if #(
    parameter int unsigned PCW = 8
);
    logic           iDB;
    logic           oSHORT;
    logic           oLONG;
    logic           oREPEAT;
    logic           oHELD;
    logic [PCW-1:0] oPRESS_CNT;

    modport master (
        output iDB,
        input  oSHORT, oLONG, oREPEAT, oHELD, oPRESS_CNT
    );

    modport slave (
        input  iDB,
        output oSHORT, oLONG, oREPEAT, oHELD, oPRESS_CNT
    );
endinterface

// File: rtl/btn_event_decoder_hold_timer.sv
// Hold-time up-counter with synchronous clear and terminal-count compare,
// shared between the long-press and auto-repeat thresholds.
module btn_event_decoder_hold_timer #(
    parameter int unsigned CW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] term,
    output logic          at_term
);
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced presses as short/long, emits one-cycle event pulses and a
// wrapping press counter. Auto-repeat in long hold is built only with BTN_AUTOREPEAT_EN.
module btn_event_decoder
    import btn_event_decoder_pkg::*;
#(
    parameter int unsigned CW         = BOARD_CW,
    parameter int unsigned LONG_CYC   = BOARD_LONG_CYC,
    parameter int unsigned REPEAT_CYC = BOARD_REPEAT_CYC,
    parameter int unsigned PCW        = BOARD_PCW
) (
    input  logic               iCLK,
    input  logic               iRESET_N,
    btn_event_decoder_if.slave bus
);
    btn_state_e     state_d, state_q;
    logic           short_d, short_q;
    logic           long_d, long_q;
    logic           repeat_d, repeat_q;
    logic           held_d, held_q;
    logic [PCW-1:0] press_cnt_d, press_cnt_q;

    logic           tmr_clr;
    logic           tmr_inc;
    logic           tmr_at_term;
    logic [CW-1:0]  tmr_term;

    // One comparator serves both thresholds; the limit follows the current state.
    assign tmr_term = (state_q == ST_LONG) ? CW'(REPEAT_CYC - 1) : CW'(LONG_CYC - 1);

    btn_event_decoder_hold_timer #(
        .CW (CW)
    ) u_hold_timer (
        .clk     (iCLK),
        .rst_n   (iRESET_N),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .term    (tmr_term),
        .at_term (tmr_at_term)
    );

    always_comb begin
        state_d     = state_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        press_cnt_d = press_cnt_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (bus.iDB) begin
                    state_d     = ST_PRESS;
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            ST_PRESS: begin
                if (!bus.iDB) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    tmr_clr = 1'b1;
                end else if (tmr_at_term) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_LONG: begin
                if (!bus.iDB) begin
                    state_d = ST_IDLE;
                    tmr_clr = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (tmr_at_term) begin
                        repeat_d = 1'b1;
                        tmr_clr  = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
`else
                    tmr_clr = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_clr = 1'b1;
            end
        endcase

        held_d = (state_d == ST_PRESS) || (state_d == ST_LONG);
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET_N) begin
            state_q     <= ST_IDLE;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus.oSHORT     = short_q;
    assign bus.oLONG      = long_q;
    assign bus.oREPEAT    = repeat_q;
    assign bus.oHELD      = held_q;
    assign bus.oPRESS_CNT = press_cnt_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder with reduced cycle constants; works with
// or without BTN_AUTOREPEAT_EN.
module tb_btn_event_decoder;
    import btn_event_decoder_pkg::*;

    localparam int unsigned LC  = SIM_LONG_CYC;
    localparam int unsigned RC  = SIM_REPEAT_CYC;
    localparam int unsigned PCW = 8;

    logic clk;
    logic rst_n;

    btn_event_decoder_if #(.PCW(PCW)) dut_if ();

    btn_event_decoder #(
        .CW         (SIM_CW),
        .LONG_CYC   (LC),
        .REPEAT_CYC (RC),
        .PCW        (PCW)
    ) dut (
        .iCLK     (clk),
        .iRESET_N (rst_n),
        .bus      (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned    n_cmp  = 0;
    int unsigned    n_fail = 0;

    // Reference model: press length counted in sampled-high edges since the press began.
    bit             m_pressed = 1'b0;
    int unsigned    m_hold    = 0;
    logic [PCW-1:0] m_cnt     = '0;
    logic           e_short, e_long, e_rep, e_held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic db, input logic rstn);
        @(negedge clk);
        dut_if.iDB = db;
        rst_n      = rstn;
        @(posedge clk);
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (!rstn) begin
            m_pressed = 1'b0;
            m_hold    = 0;
            m_cnt     = '0;
        end else if (!m_pressed) begin
            if (db) begin
                m_pressed = 1'b1;
                m_hold    = 1;
                m_cnt     = m_cnt + 1'b1;
            end
        end else if (!db) begin
            m_pressed = 1'b0;
            e_short   = (m_hold <= LC);
        end else begin
            m_hold++;
            e_long = (m_hold == LC + 1);
`ifdef BTN_AUTOREPEAT_EN
            e_rep  = (m_hold > LC + 1) && (((m_hold - LC - 1) % RC) == 0);
`endif
        end
        e_held = m_pressed;
        #1;
        chk("short",  32'(dut_if.oSHORT),     32'(e_short));
        chk("long",   32'(dut_if.oLONG),      32'(e_long));
        chk("repeat", 32'(dut_if.oREPEAT),    32'(e_rep));
        chk("held",   32'(dut_if.oHELD),      32'(e_held));
        chk("count",  32'(dut_if.oPRESS_CNT), 32'(m_cnt));
    endtask

    task automatic press(input int unsigned high_edges, input int unsigned low_edges);
        for (int unsigned i = 0; i < high_edges; i++) step(1'b1, 1'b1);
        for (int unsigned i = 0; i < low_edges; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        dut_if.iDB = 1'b0;
        rst_n      = 1'b0;

        // Reset with button already down, then release: counts as a new press.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_held", 32'(dut_if.oHELD), 32'd0);
        step(1'b1, 1'b1);
        chk("rel_held", 32'(dut_if.oHELD), 32'd1);
        chk("rel_cnt",  32'(dut_if.oPRESS_CNT), 32'd1);
        press(2, 3);
        chk("first_cnt", 32'(dut_if.oPRESS_CNT), 32'd1);

        // Short press of 3 edges.
        press(3, 3);
        // Release exactly on the threshold edge: still short.
        press(LC, 3);
        // One more high edge: long.
        press(LC + 1, 3);
        // Long hold with repeats, then release.
        press(LC + 1 + 3 * RC, 4);
        chk("cnt_after_long", 32'(dut_if.oPRESS_CNT), 32'd5);

        // Reset during long hold aborts silently.
        press(10, 0);
        step(1'b1, 1'b0);
        chk("abort_cnt",  32'(dut_if.oPRESS_CNT), 32'd0);
        chk("abort_held", 32'(dut_if.oHELD), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Counter wrap.
        for (int unsigned i = 0; i < 256; i++) press($urandom_range(1, 3), $urandom_range(1, 2));
        chk("wrap256", 32'(dut_if.oPRESS_CNT), 32'd0);
        press(2, 1);
        chk("wrap257", 32'(dut_if.oPRESS_CNT), 32'd1);

        // Random segments of alternating level, occasional reset.
        for (int unsigned s = 0; s < 60; s++) begin
            int unsigned len;
            len = $urandom_range(1, 3 * (LC + RC));
            for (int unsigned i = 0; i < len; i++) begin
                step(s[0] == 1'b0, ($urandom_range(0, 99) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
